// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared CPU definitions for next-PC sequencing.
// Redirect kinds, boot/exception vectors and sequencer states.
package pc_redirect_ctrl_pkg;

    localparam logic [31:0] RESET_VEC = 32'hBFC0_0000;
    localparam logic [31:0] EXC_VEC   = 32'hBFC0_0380;

    // Numeric order of the kinds equals their priority.
    typedef enum logic [1:0] {
        RK_NONE = 2'd0,
        RK_BR   = 2'd1,
        RK_ERET = 2'd2,
        RK_EXC  = 2'd3
    } redir_kind_e;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } redir_state_e;

    typedef struct packed {
        redir_kind_e kind;
        logic [31:0] target;
    } redir_t;

    localparam redir_t REDIR_NONE = '{kind: RK_NONE, target: 32'h0};

    // Collapse the three request pulses into one (kind, target) pair.
    function automatic redir_t req_encode(
        input logic        exc,
        input logic        eret,
        input logic        br,
        input logic [31:0] epc,
        input logic [31:0] br_target
    );
        redir_t r;
        r = REDIR_NONE;
        if (exc) begin
            r.kind   = RK_EXC;
            r.target = EXC_VEC;
        end else if (eret) begin
            r.kind   = RK_ERET;
            r.target = epc;
        end else if (br) begin
            r.kind   = RK_BR;
            r.target = br_target;
        end
        return r;
    endfunction

    // Exceptions and ERET change privilege context, so IF/ID must die.
    function automatic logic kind_flushes(input redir_kind_e k);
        return (k == RK_EXC) || (k == RK_ERET);
    endfunction

endpackage

// File: rtl/pc_redirect_ctrl_redirect_prio_sel.sv
// Two-way redirect priority selector.
// Returns the higher-priority pair; ties keep operand a.
module redirect_prio_sel
    import pc_redirect_ctrl_pkg::*;
(
    input  redir_t a_i,
    input  redir_t b_i,
    output redir_t win_o
);

    // Operand b only wins when strictly higher than operand a.
    always_comb begin
        win_o = a_i;
        if (b_i.kind > a_i.kind) begin
            win_o = b_i;
        end
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Next-PC sequencer for the IF stage.
// Arbitrates redirects and parks them across stalls.
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic [31:0] pc_cur,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        exc_valid,
    input  logic        eret_valid,
    input  logic [31:0] epc,
    output logic [31:0] next_pc,
    output logic        flush,
    output logic        redirect_pending
);

    redir_state_e state_q;
    redir_state_e state_d;
    redir_t       buf_q;
    redir_t       buf_d;
    redir_t       req;
    redir_t       win;

    // Current-cycle request, already priority-resolved among sources.
    always_comb begin
        req = req_encode(exc_valid, eret_valid, br_valid,
                         epc, br_target);
    end

    // Buffered entry is operand a, so it wins ties on merge; the
    // buffer is empty in RUN, so the same path serves capture.
    redirect_prio_sel u_prio_sel (
        .a_i   (buf_q),
        .b_i   (req),
        .win_o (win)
    );

    // Next-state, buffer update and next-PC selection.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        next_pc = RESET_VEC;
        flush   = 1'b0;
        case (state_q)
            ST_RUN, ST_PEND: begin
                if (stall) begin
                    next_pc = pc_cur;
                    buf_d   = win;
                    if (win.kind == RK_NONE) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_PEND;
                    end
                end else begin
                    if (win.kind == RK_NONE) begin
                        next_pc = pc_cur + 32'd4;
                    end else begin
                        next_pc = win.target;
                    end
                    flush   = kind_flushes(win.kind);
                    buf_d   = REDIR_NONE;
                    state_d = ST_RUN;
                end
            end
            default: begin
                next_pc = RESET_VEC;
                buf_d   = REDIR_NONE;
                state_d = ST_RUN;
            end
        endcase
    end

    // State and pending buffer registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            buf_q   <= REDIR_NONE;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
        end
    end

    // A parked redirect exists exactly while in PEND.
    always_comb begin
        redirect_pending = (state_q == ST_PEND);
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Testbench for pc_redirect_ctrl.
// Directed plan steps then random traffic against a reference model.
module tb_pc_redirect_ctrl;

    localparam logic [31:0] RV = 32'hBFC0_0000;
    localparam logic [31:0] EV = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [31:0] pc_cur;
    logic        br_valid;
    logic [31:0] br_target;
    logic        exc_valid;
    logic        eret_valid;
    logic [31:0] epc;
    logic [31:0] next_pc;
    logic        flush;
    logic        redirect_pending;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: booting flag plus a pending rank/target.
    bit          m_boot;
    int          m_rank;
    logic [31:0] m_tgt;

    logic [31:0] o_pc;
    logic        o_fl;
    logic        o_pd;

    pc_redirect_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .pc_cur           (pc_cur),
        .br_valid         (br_valid),
        .br_target        (br_target),
        .exc_valid        (exc_valid),
        .eret_valid       (eret_valid),
        .epc              (epc),
        .next_pc          (next_pc),
        .flush            (flush),
        .redirect_pending (redirect_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        stall      = 1'b0;
        br_valid   = 1'b0;
        br_target  = 32'h0;
        exc_valid  = 1'b0;
        eret_valid = 1'b0;
        epc        = 32'h0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        @(posedge clk);
        #1;
        chk("rst_pc", next_pc, RV);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_pend", {31'd0, redirect_pending}, 32'd0);
        rst_n  = 1'b1;
        m_boot = 1'b1;
        m_rank = 0;
        m_tgt  = 32'h0;
    endtask

    // One clock cycle: drive, check vs model at mid-cycle, advance.
    task automatic step(input bit st, input logic [31:0] pc,
                        input bit b, input logic [31:0] bt,
                        input bit e, input bit er,
                        input logic [31:0] ep);
        int          rq;
        logic [31:0] rt;
        int          w;
        logic [31:0] wt;
        logic [31:0] e_pc;
        bit          e_fl;
        bit          e_pd;
        stall      = st;
        pc_cur     = pc;
        br_valid   = b;
        br_target  = bt;
        exc_valid  = e;
        eret_valid = er;
        epc        = ep;
        #4;
        rq = e ? 3 : (er ? 2 : (b ? 1 : 0));
        rt = e ? EV : (er ? ep : (b ? bt : 32'h0));
        e_pd = (m_rank != 0);
        if (m_boot) begin
            e_pc   = RV;
            e_fl   = 1'b0;
            m_boot = 1'b0;
            m_rank = 0;
        end else begin
            if (rq > m_rank) begin
                w  = rq;
                wt = rt;
            end else begin
                w  = m_rank;
                wt = m_tgt;
            end
            if (st) begin
                e_pc   = pc;
                e_fl   = 1'b0;
                m_rank = w;
                m_tgt  = wt;
            end else begin
                e_pc   = (w == 0) ? pc + 32'd4 : wt;
                e_fl   = (w >= 2);
                m_rank = 0;
            end
        end
        o_pc = next_pc;
        o_fl = flush;
        o_pd = redirect_pending;
        chk("m_pc", o_pc, e_pc);
        chk("m_flush", {31'd0, o_fl}, {31'd0, e_fl});
        chk("m_pend", {31'd0, o_pd}, {31'd0, e_pd});
        @(posedge clk);
        #1;
    endtask

    initial begin
        pc_cur = 32'h0;
        do_reset();

        // Boot cycle, then sequential.
        step(0, 32'h1234_0000, 1, 32'h4444_0000, 1, 0, 32'h0);
        chk("boot_pc", o_pc, RV);
        chk("boot_flush", {31'd0, o_fl}, 32'd0);
        step(0, RV, 0, 0, 0, 0, 0);
        chk("seq_pc", o_pc, 32'hBFC0_0004);

        // Branch while running.
        step(0, 32'hBFC0_0010, 1, 32'hBFC0_0100, 0, 0, 0);
        chk("br_pc", o_pc, 32'hBFC0_0100);
        chk("br_pend", {31'd0, o_pd}, 32'd0);

        // Branch during a 3-cycle stall.
        step(1, 32'hBFC0_0100, 1, 32'h8000_1000, 0, 0, 0);
        chk("stb_hold", o_pc, 32'hBFC0_0100);
        step(1, 32'hBFC0_0100, 0, 0, 0, 0, 0);
        chk("stb_pend", {31'd0, o_pd}, 32'd1);
        step(1, 32'hBFC0_0100, 0, 0, 0, 0, 0);
        step(0, 32'hBFC0_0100, 0, 0, 0, 0, 0);
        chk("stb_apply", o_pc, 32'h8000_1000);
        step(0, 32'h8000_1000, 0, 0, 0, 0, 0);
        chk("stb_clr", {31'd0, o_pd}, 32'd0);
        chk("stb_seq", o_pc, 32'h8000_1004);

        // Pending branch upgraded by exception.
        step(1, 32'h8000_0040, 1, 32'h8000_1000, 0, 0, 0);
        step(1, 32'h8000_0040, 0, 0, 1, 0, 0);
        step(0, 32'h8000_0040, 0, 0, 0, 0, 0);
        chk("upg_pc", o_pc, EV);
        chk("upg_flush", {31'd0, o_fl}, 32'd1);
        step(0, EV, 0, 0, 0, 0, 0);
        chk("upg_noreplay", o_pc, 32'hBFC0_0384);

        // Pending exception not overwritten by branch.
        step(1, 32'h8000_0080, 0, 0, 1, 0, 0);
        step(1, 32'h8000_0080, 1, 32'h8000_2000, 0, 0, 0);
        step(0, 32'h8000_0080, 1, 32'h8000_3000, 0, 0, 0);
        chk("keep_exc", o_pc, EV);

        // Simultaneous sources.
        step(0, 32'h8000_0100, 1, 32'h8000_1000, 1, 1, 32'h8000_0020);
        chk("sim3_pc", o_pc, EV);
        chk("sim3_flush", {31'd0, o_fl}, 32'd1);
        step(0, 32'h8000_0100, 1, 32'h8000_1000, 0, 1, 32'h8000_0020);
        chk("sim2_pc", o_pc, 32'h8000_0020);
        chk("sim2_flush", {31'd0, o_fl}, 32'd1);

        // Reset while an eret is pending.
        step(1, 32'h8000_0200, 0, 0, 0, 1, 32'h8000_0020);
        step(1, 32'h8000_0200, 0, 0, 0, 0, 0);
        chk("rpend_pre", {31'd0, o_pd}, 32'd1);
        do_reset();
        step(0, 32'h8000_0200, 0, 0, 0, 0, 0);
        chk("rpend_boot", o_pc, RV);
        chk("rpend_pd", {31'd0, o_pd}, 32'd0);

        // Wrap at top of address space.
        step(0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
        chk("wrap", o_pc, 32'h0000_0000);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC
                                              : {$urandom} & ~32'd3;
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end
            step(bit'($urandom_range(0, 1)), rpc,
                 bit'($urandom_range(0, 3) == 0), $urandom,
                 bit'($urandom_range(0, 7) == 0),
                 bit'($urandom_range(0, 5) == 0), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Next-PC sequencer for the instruction-fetch stage. Each cycle it arbitrates between sequential fetch, taken branch/jump, exception entry and ERET return, and drives the next-PC input of the fetch PC register. Redirect pulses that arrive while the pipeline is stalled are captured in a one-entry priority buffer and applied on the first unstalled cycle, so no redirect is lost. It sits between the ID/EX redirect sources plus the CP0 exception logic and the IF-stage PC register.

## Interface
- RESET_VEC, 32'hBFC00000: boot address, used on the first cycle after reset.
- EXC_VEC, 32'hBFC00380: general exception entry address.
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- stall  in  1  OR of all fetch stalls (hazard, exe, mfc0); PC must hold while high
- pc_cur  in  32  PC currently being fetched
- br_valid  in  1  single-cycle pulse: taken branch/jump resolved in ID (delay slot is in IF)
- br_target  in  32  branch/jump target; valid with br_valid
- exc_valid  in  1  single-cycle pulse: exception committed
- eret_valid  in  1  single-cycle pulse: ERET committed
- epc  in  32  return address; valid with eret_valid
- next_pc  out  32  next-PC value for the PC register
- flush  out  1  kill IF/ID contents; pulses when an exception or ERET redirect is applied
- redirect_pending  out  1  a captured redirect is waiting for stall to drop

## Operation
- States: BOOT, RUN, PEND.
- BOOT is entered on reset. It lasts one cycle: next_pc = RESET_VEC, flush = 0. It then moves to RUN. Any redirect inputs in BOOT are ignored.
- Request priority, highest first: exc > eret > br > sequential.
- Pending buffer: a kind field (NONE/BR/ERET/EXC) plus a 32-bit target.
- RUN with stall = 0:
  - next_pc is the highest-priority active request's target: EXC_VEC, epc or br_target.
  - With no active request, next_pc = pc_cur + 4 (mod 2^32; 32'hFFFFFFFC wraps to 0).
  - flush = 1 only for exc or eret.
- RUN with stall = 1:
  - next_pc = pc_cur (hold).
  - Any active request is written into the buffer and the state moves to PEND. flush = 0.
- PEND with stall = 1:
  - next_pc = pc_cur.
  - A new request replaces the buffer only if its priority is strictly higher than the buffered kind. An exc therefore overwrites a pending br or eret; a br never overwrites a pending exc.
- PEND with stall = 0:
  - A new request that same cycle is merged by priority with the buffered one. On equal kinds, the buffered one wins.
  - next_pc = winner target. flush = 1 if the winner is exc or eret.
  - The buffer is cleared and the state returns to RUN.
- redirect_pending = 1 exactly when state == PEND.
- An exception applied in any state discards any buffered br or eret. A branch is never re-executed after the exception handler is entered.

## Timing
- next_pc and flush are combinational from the inputs, state and buffer. Latency is zero cycles: a request in cycle N, with stall = 0, sets next_pc in cycle N, so the PC register loads it at the end of cycle N.
- Buffered redirect: it is applied in the first cycle with stall = 0, and never sooner.
- State and buffer update on posedge clk.
- Reset values, and values in BOOT: state = BOOT, buffer kind = NONE, buffer target = 0, next_pc = RESET_VEC, flush = 0, redirect_pending = 0.
- Reset asserted mid-PEND drops the buffered request.
- Simultaneous exc and br in one cycle: exc wins and br is dropped, with no later replay.
- Request pulses are sampled only in RUN and PEND.

## Structure
- Shared CPU package holds:
  - the redirect-kind encoding: NONE = 2'd0, BR = 2'd1, ERET = 2'd2, EXC = 2'd3, with numeric order equal to priority;
  - the RESET_VEC and EXC_VEC constants, shared with CP0;
  - the state encoding.
- One natural sub-module, redirect_prio_sel. It is combinational: it takes two (kind, target) pairs and returns the higher-priority pair, with a tie going to the first operand. It is used for both the capture path and the merge path.

## Test plan
- Reset release: rst_n 0→1 → next_pc = 32'hBFC00000 for one cycle; the next cycle with pc_cur = 32'hBFC00000 gives next_pc = 32'hBFC00004, flush = 0.
- Branch while running: pc_cur = 32'hBFC00010, br_valid with br_target = 32'hBFC00100, stall = 0 → next_pc = 32'hBFC00100 the same cycle, flush = 0, redirect_pending stays 0.
- Branch during stall: br_valid with target 32'h80001000 while stall = 1 for 3 cycles → next_pc = pc_cur and redirect_pending = 1 for those cycles; first cycle with stall = 0 gives next_pc = 32'h80001000, then redirect_pending = 0.
- Priority upgrade in PEND: br pending (32'h80001000), then exc_valid while still stalled, then stall drops → next_pc = 32'hBFC00380, flush = 1; the next cycle is sequential (pc_cur + 4), with no branch replay.
- Simultaneous sources: exc_valid, eret_valid (epc = 32'h80000020) and br_valid together, stall = 0 → next_pc = 32'hBFC00380, flush = 1. Repeat with eret and br only → next_pc = 32'h80000020, flush = 1.
- Edge cases:
  - reset asserted while PEND holds an eret → after release, BOOT gives next_pc = RESET_VEC and redirect_pending = 0;
  - pc_cur = 32'hFFFFFFFC with no request → next_pc = 32'h00000000.
